ace_snoop_sequencer: RTL and testbench

//  Sequences one snoop transaction at a time for the ACE interconnect, downstream of the AR decoder.

---
 rtl/ace_snoop_sequencer_pkg.sv | 81 ++++++++
 rtl/ace_snoop_sequencer_cr_merge.sv | 36 +++
 rtl/ace_snoop_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ace_snoop_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_snoop_sequencer_pkg.sv
// Shared types for the ACE snoop sequencer: AC opcodes, decoder snoop info,
// CRRESP bit positions, the CR accumulator and the merged snoop result.
package ace_snoop_sequencer_pkg;

  // CRRESP bit positions {WasUnique,IsShared,PassDirty,Error,DataTransfer}
  localparam int unsigned CR_DT  = 0;
  localparam int unsigned CR_ERR = 1;
  localparam int unsigned CR_PD  = 2;
  localparam int unsigned CR_IS  = 3;
  localparam int unsigned CR_WU  = 4;
  localparam int unsigned CrRespWidth  = 5;
  // data_src is sized for up to 256 masters; narrower indices are zero-extended
  localparam int unsigned DataSrcWidth = 8;

  typedef enum logic [3:0] {
    AcReadOnce           = 4'b0000,
    AcReadShared         = 4'b0001,
    AcReadClean          = 4'b0010,
    AcReadNotSharedDirty = 4'b0011,
    AcReadUnique         = 4'b0111,
    AcCleanShared        = 4'b1000,
    AcCleanInvalid       = 4'b1001,
    AcMakeInvalid        = 4'b1101,
    AcDvmComplete        = 4'b1110,
    AcDvmMessage         = 4'b1111
  } acsnoop_t;

  typedef struct packed {
    acsnoop_t snoop_trs;
    logic     accepts_dirty;
    logic     accepts_shared;
    logic     excl_load;
    logic     excl_store;
  } snoop_info_t;

  typedef struct packed {
    logic                    data_valid;
    logic [DataSrcWidth-1:0] data_src;
    logic                    is_shared;
    logic                    was_unique;
    logic                    pass_dirty;
    logic                    needs_wb;
    logic                    excl_fail;
    logic                    err;
    logic                    timeout;
  } snoop_result_t;

  // Running fold of every CR accepted for the current transaction
  typedef struct packed {
    logic                    data_valid;
    logic [DataSrcWidth-1:0] data_src;
    logic                    is_shared;
    logic                    was_unique;
    logic                    pass_dirty;
    logic                    err;
    logic                    any_cr;
  } cr_acc_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSnoop = 2'd1,
    StResp  = 2'd2
  } seq_state_e;

  // Turn the accumulator plus the request attributes into the result seen by the read path
  function automatic snoop_result_t build_result(input cr_acc_t acc, input logic accepts_dirty,
                                                 input logic excl_store, input logic timeout);
    snoop_result_t r;
    r.data_valid = acc.data_valid;
    r.data_src   = acc.data_src;
    r.is_shared  = acc.is_shared;
    r.was_unique = acc.was_unique;
    r.pass_dirty = acc.pass_dirty;
    r.needs_wb   = acc.pass_dirty & ~accepts_dirty;
    r.excl_fail  = excl_store & ~acc.was_unique & acc.any_cr;
    r.err        = acc.err | timeout;
    r.timeout    = timeout;
    return r;
  endfunction

endpackage

// File: rtl/ace_snoop_sequencer_cr_merge.sv
// Combinational fold of the CR responses accepted this cycle into the accumulator.
// Flags are ORed; data_src keeps the lowest master index that transferred data,
// regardless of the order in which responses arrived.
module ace_cr_merge
  import ace_snoop_sequencer_pkg::*;
#(
  parameter int unsigned NumMasters = 4
) (
  input  cr_acc_t                               acc_i,
  input  logic [NumMasters-1:0]                 cr_hs_i,
  input  logic [NumMasters*CrRespWidth-1:0]     cr_resp_i,
  output cr_acc_t                               acc_o
);

  // Fold each handshaking master in index order so a lower index wins data_src
  always_comb begin
    logic [CrRespWidth-1:0] r;
    r     = '0;
    acc_o = acc_i;
    for (int i = 0; i < NumMasters; i++) begin
      if (cr_hs_i[i]) begin
        r                = cr_resp_i[i*CrRespWidth +: CrRespWidth];
        acc_o.any_cr     = 1'b1;
        acc_o.is_shared  = acc_o.is_shared  | r[CR_IS];
        acc_o.was_unique = acc_o.was_unique | r[CR_WU];
        acc_o.pass_dirty = acc_o.pass_dirty | r[CR_PD];
        acc_o.err        = acc_o.err        | r[CR_ERR];
        if (r[CR_DT] && (!acc_o.data_valid || (DataSrcWidth'(i) < acc_o.data_src))) begin
          acc_o.data_valid = 1'b1;
          acc_o.data_src   = DataSrcWidth'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ace_snoop_sequencer.sv
// ACE snoop sequencer: accepts one decoded request, broadcasts AC to every
// master except the initiator, collects each CR and returns one merged result.
// Optional feature macro: ACE_SNOOP_TIMEOUT_EN (abort SNOOP after TimeoutCycles).
//
// Handshakes: every channel is valid/ready; a transfer happens on a rising edge
// where both are high. Once raised, valid and its payload hold until accepted
// (reset excepted: reset drops ac_valid_o without a handshake).
module ace_snoop_sequencer
  import ace_snoop_sequencer_pkg::*;
#(
  parameter  int unsigned NumMasters    = 4,
  parameter  int unsigned AddrWidth     = 64,
  parameter  int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxWidth      = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [AddrWidth-1:0]              req_addr_i,
  input  logic                              req_snooping_i,
  input  snoop_info_t                       req_info_i,
  input  logic [IdxWidth-1:0]               req_src_i,
  output logic [NumMasters-1:0]             ac_valid_o,
  input  logic [NumMasters-1:0]             ac_ready_i,
  output logic [AddrWidth-1:0]              ac_addr_o,
  output acsnoop_t                          ac_snoop_o,
  input  logic [NumMasters-1:0]             cr_valid_i,
  output logic [NumMasters-1:0]             cr_ready_o,
  input  logic [NumMasters*CrRespWidth-1:0] cr_resp_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output snoop_result_t                     resp_o,
  output seq_state_e                        dbg_state_o
);

  seq_state_e            state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  snoop_info_t           info_q, info_d;
  logic [NumMasters-1:0] mask_q, mask_d;
  logic [NumMasters-1:0] ac_done_q, ac_done_d;
  logic [NumMasters-1:0] cr_done_q, cr_done_d;
  cr_acc_t               acc_q, acc_d;
  cr_acc_t               acc_merged;
  logic [NumMasters-1:0] src_mask;
  logic [NumMasters-1:0] ac_hs;
  logic [NumMasters-1:0] cr_hs;
  logic                  timeout_w;

`ifdef ACE_SNOOP_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  assign timeout_w = timeout_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TimeoutCycles);
  assign timeout_w = 1'b0;
`endif

  // Policy bits the merge does not consume
  logic unused_info;
  assign unused_info = info_q.accepts_shared ^ info_q.excl_load;

  // Every master except the initiator is a snoop target
  assign src_mask = ~(NumMasters'(1) << req_src_i);

  // Channel strobes derive only from registered state
  assign ac_valid_o   = (state_q == StSnoop) ? (mask_q & ~ac_done_q) : '0;
  assign cr_ready_o   = (state_q == StSnoop) ? (ac_done_q & ~cr_done_q) : '0;
  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign ac_hs        = ac_valid_o & ac_ready_i;
  assign cr_hs        = cr_valid_i & cr_ready_o;
  assign ac_addr_o    = addr_q;
  assign ac_snoop_o   = info_q.snoop_trs;
  assign dbg_state_o  = state_q;
  assign resp_o       = build_result(acc_q, info_q.accepts_dirty, info_q.excl_store, timeout_w);

  ace_cr_merge #(
    .NumMasters (NumMasters)
  ) u_cr_merge (
    .acc_i     (acc_q),
    .cr_hs_i   (cr_hs),
    .cr_resp_i (cr_resp_i),
    .acc_o     (acc_merged)
  );

  // Next-state logic: accept in IDLE, track AC/CR bitmaps in SNOOP, hold the result in RESP
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    info_d    = info_q;
    mask_d    = mask_q;
    ac_done_d = ac_done_q;
    cr_done_d = cr_done_q;
    acc_d     = acc_q;
`ifdef ACE_SNOOP_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          info_d    = req_info_i;
          mask_d    = src_mask;
          ac_done_d = '0;
          cr_done_d = '0;
          acc_d     = '0;
`ifdef ACE_SNOOP_TIMEOUT_EN
          cnt_d     = '0;
          timeout_d = 1'b0;
`endif
          // No snoop needed, or nobody to snoop: report the empty merge directly
          state_d   = (req_snooping_i && (|src_mask)) ? StSnoop : StResp;
        end
      end
      StSnoop: begin
        ac_done_d = ac_done_q | ac_hs;
        cr_done_d = cr_done_q | cr_hs;
        acc_d     = acc_merged;
`ifdef ACE_SNOOP_TIMEOUT_EN
        cnt_d     = cnt_q + 32'd1;
`endif
        // Leave in the same cycle the last CR lands
        if (cr_done_d == mask_q) begin
          state_d = StResp;
        end
`ifdef ACE_SNOOP_TIMEOUT_EN
        else if (cnt_q == 32'(TimeoutCycles - 1)) begin
          state_d   = StResp;
          timeout_d = 1'b1;
        end
`endif
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      info_q    <= '0;
      mask_q    <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      acc_q     <= '0;
`ifdef ACE_SNOOP_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      info_q    <= info_d;
      mask_q    <= mask_d;
      ac_done_q <= ac_done_d;
      cr_done_q <= cr_done_d;
      acc_q     <= acc_d;
`ifdef ACE_SNOOP_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_ace_snoop_sequencer.sv
// Directed bench for ace_snoop_sequencer (4 masters). A per-master responder
// runs on the falling edge; expected merged results are hand-computed.
module tb_ace_snoop_sequencer;
  import ace_snoop_sequencer_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [AW-1:0]         req_addr_i;
  logic                  req_snooping_i;
  snoop_info_t           req_info_i;
  logic [IW-1:0]         req_src_i;
  logic [N-1:0]          ac_valid_o;
  logic [N-1:0]          ac_ready_i;
  logic [AW-1:0]         ac_addr_o;
  acsnoop_t              ac_snoop_o;
  logic [N-1:0]          cr_valid_i;
  logic [N-1:0]          cr_ready_o;
  logic [N*5-1:0]        cr_resp_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  snoop_result_t         resp_o;
  seq_state_e            dbg_state_o;

  int checks = 0;
  int errors = 0;
  snoop_result_t exp_q[$];

  // Responder configuration and per-transaction progress
  logic [4:0]   m_resp [N];
  int           m_dly  [N];
  int           m_stall[N];
  logic [N-1:0] ac_got, cr_sent, ac_seen;

  ace_snoop_sequencer #(
    .NumMasters    (N),
    .AddrWidth     (AW),
    .TimeoutCycles (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_snooping_i (req_snooping_i),
    .req_info_i     (req_info_i),
    .req_src_i      (req_src_i),
    .ac_valid_o     (ac_valid_o),
    .ac_ready_i     (ac_ready_i),
    .ac_addr_o      (ac_addr_o),
    .ac_snoop_o     (ac_snoop_o),
    .cr_valid_i     (cr_valid_i),
    .cr_ready_o     (cr_ready_o),
    .cr_resp_i      (cr_resp_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_o         (resp_o),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic snoop_result_t mk_res(input logic dv, input logic [7:0] src, input logic is,
                                           input logic wu, input logic pd, input logic wb,
                                           input logic xf, input logic er, input logic to);
    snoop_result_t r;
    r.data_valid = dv; r.data_src = src; r.is_shared = is; r.was_unique = wu;
    r.pass_dirty = pd; r.needs_wb = wb; r.excl_fail = xf; r.err = er; r.timeout = to;
    return r;
  endfunction

  function automatic snoop_info_t mk_info(input acsnoop_t op, input logic ad, input logic xs);
    snoop_info_t s;
    s.snoop_trs = op; s.accepts_dirty = ad; s.accepts_shared = 1'b1;
    s.excl_load = 1'b0; s.excl_store = xs;
    return s;
  endfunction

  task automatic cfg(input int i, input logic [4:0] r, input int d, input int s);
    m_resp[i] = r; m_dly[i] = d; m_stall[i] = s;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_req_ready"},  req_ready_o, 1'b1);
    check({tag, "_ac_valid"},   ac_valid_o, '0);
    check({tag, "_cr_ready"},   cr_ready_o, '0);
    check({tag, "_resp_valid"}, resp_valid_o, 1'b0);
    check({tag, "_ac_addr"},    ac_addr_o, '0);
    check({tag, "_ac_snoop"},   ac_snoop_o, '0);
    check({tag, "_resp"},       resp_o, '0);
    check({tag, "_state"},      dbg_state_o, StIdle);
  endtask

  // One falling-edge step of all masters: inputs set here take effect at the next rising edge
  task automatic step_masters(input logic [AW-1:0] addr, input acsnoop_t op);
    for (int i = 0; i < N; i++) begin
      cr_valid_i[i]        = 1'b0;
      cr_resp_i[i*5 +: 5]  = 5'b0;
      if (ac_got[i] && !cr_sent[i]) begin
        if (m_dly[i] > 0) m_dly[i]--;
        else begin
          cr_valid_i[i]       = 1'b1;
          cr_resp_i[i*5 +: 5] = m_resp[i];
          if (cr_ready_o[i]) cr_sent[i] = 1'b1;
        end
      end
      ac_ready_i[i] = 1'b1;
      if (ac_valid_o[i]) begin
        ac_seen[i] = 1'b1;
        if (m_stall[i] > 0) begin
          ac_ready_i[i] = 1'b0;
          m_stall[i]--;
          check("stall_addr", ac_addr_o, addr);
          check("stall_snoop", ac_snoop_o, op);
        end else begin
          ac_got[i] = 1'b1;
        end
      end
    end
  endtask

  // Drive one request and check its result; abort_at>0 asserts reset in that cycle instead
  task automatic do_txn(input logic [IW-1:0] src, input logic snp, input snoop_info_t info,
                        input logic [AW-1:0] addr, input logic [N-1:0] exp_mask,
                        input snoop_result_t exp_res, input int exp_lat,
                        input int resp_stall, input int abort_at);
    int  cyc;
    int  lat;
    bit  done;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    check("req_ready_idle", req_ready_o, 1'b1);
    ac_got = '0; cr_sent = '0; ac_seen = '0;
    req_valid_i = 1'b1; req_addr_i = addr; req_snooping_i = snp;
    req_info_i = info; req_src_i = src;
    if (abort_at == 0) exp_q.push_back(exp_res);
    cyc = 0; lat = -1; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      req_valid_i = 1'b0;
      step_masters(addr, info.snoop_trs);
      if (abort_at != 0 && cyc == abort_at) begin
        check("pre_rst_ac_valid3", ac_valid_o[3], 1'b1);
        rst_i = 1'b1; ac_ready_i = '0; cr_valid_i = '0;
        @(negedge clk_i);
        chk_reset_vals("mid_rst");
        rst_i = 1'b0;
        done = 1'b1;
      end else if (resp_valid_o) begin
        if (lat < 0) lat = cyc;
        if (resp_stall > 0) begin
          resp_stall--;
          resp_ready_i = 1'b0;
          check("resp_hold", resp_o, exp_q[0]);
          check("req_ready_busy", req_ready_o, 1'b0);
        end else begin
          resp_ready_i = 1'b1;
          check("latency", lat, exp_lat);
          check("ac_mask", ac_seen, exp_mask);
          check("resp", resp_o, exp_q.pop_front());
          done = 1'b1;
        end
      end
    end
    if (!done) check("wait_resp_budget", 1'b0, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_snooping_i = 1'b0;
    req_info_i = '0; req_src_i = '0; ac_ready_i = '0; cr_valid_i = '0;
    cr_resp_i = '0; resp_ready_i = 1'b0;
    for (int i = 0; i < N; i++) cfg(i, 5'b0, 0, 0);
    repeat (3) @(negedge clk_i);
    chk_reset_vals("reset");
    rst_i = 1'b0;

    // Plain ReadShared from master 0: snoops 1..3, empty merge, best-case latency
    for (int i = 0; i < N; i++) cfg(i, 5'b00000, 0, 0);
    do_txn(2'd0, 1'b1, mk_info(AcReadShared, 1'b0, 1'b0), 64'h0000_1000_0000_0040,
           4'b1110, mk_res(0, 8'd0, 0, 0, 0, 0, 0, 0, 0), 3, 0, 0);

    // Non-snooping request: no AC at all, result one cycle after accept
    do_txn(2'd0, 1'b0, mk_info(AcReadOnce, 1'b0, 1'b0), 64'h80,
           4'b0000, mk_res(0, 8'd0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0);

    // ReadUnique from master 1: m3 (PD,DT) lands before m2 (DT); lowest index wins
    cfg(0, 5'b00000, 1, 0); cfg(2, 5'b00001, 3, 0); cfg(3, 5'b00101, 0, 0);
    do_txn(2'd1, 1'b1, mk_info(AcReadUnique, 1'b1, 1'b0), 64'hdead_beef_0000_0100,
           4'b1101, mk_res(1, 8'd2, 0, 0, 1, 0, 0, 0, 0), 6, 0, 0);

    // CleanShared, dirty not accepted -> write-back; m3 stalls AC for 5 cycles
    cfg(1, 5'b00000, 0, 0); cfg(2, 5'b00100, 0, 0); cfg(3, 5'b00000, 0, 5);
    do_txn(2'd0, 1'b1, mk_info(AcCleanShared, 1'b0, 1'b0), 64'h1234_5678_9abc_def0,
           4'b1110, mk_res(0, 8'd0, 0, 0, 1, 1, 0, 0, 0), 8, 0, 0);

    // Exclusive store with no unique copy -> excl_fail; result held 4 cycles
    for (int i = 0; i < N; i++) cfg(i, 5'b00000, 0, 0);
    do_txn(2'd2, 1'b1, mk_info(AcReadClean, 1'b0, 1'b1), 64'h2000,
           4'b1011, mk_res(0, 8'd0, 0, 0, 0, 0, 1, 0, 0), 3, 4, 0);
    // Follow-up request right after release
    do_txn(2'd3, 1'b0, mk_info(AcReadOnce, 1'b0, 1'b0), 64'h2040,
           4'b0000, mk_res(0, 8'd0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0);

    // Exclusive store with WasUnique: no excl_fail; IsShared, Error and DT folded
    cfg(0, 5'b11000, 0, 0); cfg(1, 5'b00010, 0, 0); cfg(2, 5'b00001, 2, 0);
    do_txn(2'd3, 1'b1, mk_info(AcReadShared, 1'b1, 1'b1), 64'h3000,
           4'b0111, mk_res(1, 8'd2, 1, 1, 0, 0, 0, 1, 0), 5, 0, 0);

    // Two data sources: m3 first, m1 later -> data_src=1
    cfg(1, 5'b00001, 2, 0); cfg(2, 5'b00000, 0, 0); cfg(3, 5'b00001, 0, 0);
    do_txn(2'd0, 1'b1, mk_info(AcReadShared, 1'b0, 1'b0), 64'h4000,
           4'b1110, mk_res(1, 8'd1, 0, 0, 0, 0, 0, 0, 0), 5, 0, 0);

    // Reset while m3 still stalls its AC
    cfg(1, 5'b00000, 0, 0); cfg(2, 5'b00000, 0, 0); cfg(3, 5'b00000, 0, 100);
    do_txn(2'd0, 1'b1, mk_info(AcReadShared, 1'b0, 1'b0), 64'h5000,
           4'b1110, '0, 0, 0, 4);

    // Recovery after reset
    for (int i = 0; i < N; i++) cfg(i, 5'b00000, 0, 0);
    do_txn(2'd0, 1'b1, mk_info(AcReadShared, 1'b0, 1'b0), 64'h6000,
           4'b1110, mk_res(0, 8'd0, 0, 0, 0, 0, 0, 0, 0), 3, 0, 0);

`ifdef ACE_SNOOP_TIMEOUT_EN
    // m3 never answers its CR: abort after 16 SNOOP cycles
    cfg(3, 5'b00000, 1000, 0);
    do_txn(2'd0, 1'b1, mk_info(AcReadShared, 1'b0, 1'b0), 64'h7000,
           4'b1110, mk_res(0, 8'd0, 0, 0, 0, 0, 0, 1, 1), 17, 0, 0);
`endif

    @(negedge clk_i);
    resp_ready_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
